// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX boundary bundle: decoded ID-stage fields going in, registered EX-stage
// copies plus the load-use stall indication coming back out.
// master = ID side (drives id_*, flush, ex_hold); slave = the pipeline register.
interface id_ex_pipeline_reg_if;
  logic        id_valid;
  logic [1:0]  id_wb_ctl;
  logic [2:0]  id_m_ctl;
  logic [3:0]  id_ex_ctl;
  logic [31:0] id_npc;
  logic [31:0] id_rd_data1;
  logic [31:0] id_rd_data2;
  logic [31:0] id_sign_ext;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        flush;
  logic        ex_hold;

  logic        ex_valid;
  logic [1:0]  ex_wb_ctl;
  logic [2:0]  ex_m_ctl;
  logic [3:0]  ex_ex_ctl;
  logic [31:0] ex_npc;
  logic [31:0] ex_rd_data1;
  logic [31:0] ex_rd_data2;
  logic [31:0] ex_sign_ext;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [31:0] stall_count;

  modport master (
    output id_valid, id_wb_ctl, id_m_ctl, id_ex_ctl, id_npc, id_rd_data1,
           id_rd_data2, id_sign_ext, id_rs, id_rt, id_rd, flush, ex_hold,
    input  ex_valid, ex_wb_ctl, ex_m_ctl, ex_ex_ctl, ex_npc, ex_rd_data1,
           ex_rd_data2, ex_sign_ext, ex_rs, ex_rt, ex_rd, stall, stall_count
  );

  modport slave (
    input  id_valid, id_wb_ctl, id_m_ctl, id_ex_ctl, id_npc, id_rd_data1,
           id_rd_data2, id_sign_ext, id_rs, id_rt, id_rd, flush, ex_hold,
    output ex_valid, ex_wb_ctl, ex_m_ctl, ex_ex_ctl, ex_npc, ex_rd_data1,
           ex_rd_data2, ex_sign_ext, ex_rs, ex_rt, ex_rd, stall, stall_count
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection for the MIPS32 core.
// Edge priority: flush > hold > load-use bubble > normal load.
// Optional macro ID_EX_STALL_COUNTER_EN builds a saturating count of load-use
// bubbles; without it stall_count reads as zero.
module id_ex_pipeline_reg (
  input logic                 clk,
  input logic                 rst_n,
  id_ex_pipeline_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [3:0]  ex_ctl;
    logic [31:0] npc;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] sign_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d;
  logic     hz;
  logic     bubble_cnt;

  // Load in EX whose target is read by the ID instruction (rs and rt always
  // compared, $0 destination never hazards).
  always_comb begin
    hz = bus.id_valid & ex_q.valid & ex_q.m_ctl[1] & (ex_q.rt != 5'd0) &
         ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));
  end

  assign bus.stall  = !bus.flush & (bus.ex_hold | hz);
  assign bubble_cnt = !bus.flush & !bus.ex_hold & hz;

  // Next-state: data/address always follow ID; control is cleared for a
  // flush, a bubble or an invalid ID slot; hold freezes everything.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush || !bus.ex_hold) begin
      ex_d.npc      = bus.id_npc;
      ex_d.rd_data1 = bus.id_rd_data1;
      ex_d.rd_data2 = bus.id_rd_data2;
      ex_d.sign_ext = bus.id_sign_ext;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rd       = bus.id_rd;
      if (bus.flush || hz || !bus.id_valid) begin
        ex_d.valid  = 1'b0;
        ex_d.wb_ctl = 2'b00;
        ex_d.m_ctl  = 3'b000;
        ex_d.ex_ctl = 4'b0000;
      end else begin
        ex_d.valid  = 1'b1;
        ex_d.wb_ctl = bus.id_wb_ctl;
        ex_d.m_ctl  = bus.id_m_ctl;
        ex_d.ex_ctl = bus.id_ex_ctl;
      end
    end
  end

  // ID/EX state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_wb_ctl   = ex_q.wb_ctl;
  assign bus.ex_m_ctl    = ex_q.m_ctl;
  assign bus.ex_ex_ctl   = ex_q.ex_ctl;
  assign bus.ex_npc      = ex_q.npc;
  assign bus.ex_rd_data1 = ex_q.rd_data1;
  assign bus.ex_rd_data2 = ex_q.rd_data2;
  assign bus.ex_sign_ext = ex_q.sign_ext;
  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_rd       = ex_q.rd;

`ifdef ID_EX_STALL_COUNTER_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Saturating count of load-use bubbles only.
  always_comb begin
    stall_count_d = stall_count_q;
    if (bubble_cnt && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= 32'd0;
    else        stall_count_q <= stall_count_d;
  end

  assign bus.stall_count = stall_count_q;
`else
  logic unused_bubble_cnt;
  assign unused_bubble_cnt = bubble_cnt;
  assign bus.stall_count   = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios followed by
// random traffic, all checked against a behavioural model of the EX slot.
module tb_id_ex_pipeline_reg;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_ex_pipeline_reg_if bus ();

  id_ex_pipeline_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently occupying EX.
  typedef struct {
    bit          valid;
    bit [1:0]    wb;
    bit [2:0]    m;
    bit [3:0]    ex;
    bit [31:0]   npc, d1, d2, se;
    bit [4:0]    rs, rt, rd;
    bit [31:0]   cnt;
  } slot_t;

  slot_t mdl;

  function automatic bit model_hazard();
    bit reads_load_dest;
    reads_load_dest = (mdl.rt == bus.id_rs) || (mdl.rt == bus.id_rt);
    return bus.id_valid && mdl.valid && (mdl.m[1] == 1'b1) && (mdl.rt != 0) && reads_load_dest;
  endfunction

  function automatic bit model_stall();
    if (bus.flush) return 1'b0;
    return bus.ex_hold || model_hazard();
  endfunction

  task automatic model_reset();
    mdl = '{default: 0};
  endtask

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (!bus.flush && bus.ex_hold) return;
    mdl.npc = bus.id_npc;  mdl.d1 = bus.id_rd_data1; mdl.d2 = bus.id_rd_data2;
    mdl.se  = bus.id_sign_ext;
    mdl.rs  = bus.id_rs;   mdl.rt = bus.id_rt;  mdl.rd = bus.id_rd;
    if (!bus.flush && !hz && bus.id_valid) begin
      mdl.valid = 1; mdl.wb = bus.id_wb_ctl; mdl.m = bus.id_m_ctl; mdl.ex = bus.id_ex_ctl;
    end else begin
      mdl.valid = 0; mdl.wb = 0; mdl.m = 0; mdl.ex = 0;
    end
`ifdef ID_EX_STALL_COUNTER_EN
    if (!bus.flush && hz && mdl.cnt != 32'hFFFF_FFFF) mdl.cnt = mdl.cnt + 1;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".ex_valid"},    {31'd0, bus.ex_valid}, {31'd0, mdl.valid});
    chk({tag, ".ex_wb_ctl"},   {30'd0, bus.ex_wb_ctl}, {30'd0, mdl.wb});
    chk({tag, ".ex_m_ctl"},    {29'd0, bus.ex_m_ctl},  {29'd0, mdl.m});
    chk({tag, ".ex_ex_ctl"},   {28'd0, bus.ex_ex_ctl}, {28'd0, mdl.ex});
    chk({tag, ".ex_npc"},      bus.ex_npc,      mdl.npc);
    chk({tag, ".ex_rd_data1"}, bus.ex_rd_data1, mdl.d1);
    chk({tag, ".ex_rd_data2"}, bus.ex_rd_data2, mdl.d2);
    chk({tag, ".ex_sign_ext"}, bus.ex_sign_ext, mdl.se);
    chk({tag, ".ex_rs"},       {27'd0, bus.ex_rs}, {27'd0, mdl.rs});
    chk({tag, ".ex_rt"},       {27'd0, bus.ex_rt}, {27'd0, mdl.rt});
    chk({tag, ".ex_rd"},       {27'd0, bus.ex_rd}, {27'd0, mdl.rd});
    chk({tag, ".stall_count"}, bus.stall_count, mdl.cnt);
  endtask

  // Called at posedge+1 with inputs applied: check stall, clock, check EX.
  task automatic step(input string tag);
    #3;
    chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, model_stall()});
    @(posedge clk);
    model_edge();
    #1;
    chk_outputs(tag);
  endtask

  task automatic set_id(input bit v, input bit [1:0] wb, input bit [2:0] m, input bit [3:0] ex,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    bus.id_valid = v;  bus.id_wb_ctl = wb; bus.id_m_ctl = m; bus.id_ex_ctl = ex;
    bus.id_rs = rs;    bus.id_rt = rt;     bus.id_rd = rd;
    bus.id_npc = $urandom; bus.id_rd_data1 = $urandom;
    bus.id_rd_data2 = $urandom; bus.id_sign_ext = $urandom;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.flush = 0; bus.ex_hold = 0;
    set_id(1, 2'b10, 3'b000, 4'b0011, 5'd1, 5'd2, 5'd3);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset0.stall", {31'd0, bus.stall}, 32'd0);
    chk_outputs("reset0");
    @(posedge clk); #1 rst_n = 1'b1;

    // Pass-through
    set_id(1, 2'h2, 3'h0, 4'h3, 5'd3, 5'd4, 5'd7);
    bus.id_sign_ext = 32'hFFFFE13F;
    step("pass");
    chk("pass.const_se", bus.ex_sign_ext, 32'hFFFFE13F);

    // Load-use: lw $5 then a reader of $5
    set_id(1, 2'b11, 3'b010, 4'b0001, 5'd9, 5'd5, 5'd0);
    step("lw5");
    set_id(1, 2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd8);
    step("lu_bubble");
    chk("lu_bubble.valid_const", {31'd0, bus.ex_valid}, 32'd0);
    step("lu_load");
    chk("lu_load.valid_const", {31'd0, bus.ex_valid}, 32'd1);

    // No false hazard on $0
    set_id(1, 2'b11, 3'b010, 4'b0001, 5'd9, 5'd0, 5'd0);
    step("lw0");
    set_id(1, 2'b10, 3'b000, 4'b1100, 5'd0, 5'd6, 5'd8);
    step("nohz");

    // Flush beats hazard
    set_id(1, 2'b11, 3'b010, 4'b0001, 5'd9, 5'd7, 5'd0);
    step("lw7");
    set_id(1, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd7, 5'd8);
    bus.flush = 1;
    step("flush_hz");
    bus.flush = 0;

    // Hold for three cycles with changing ID inputs, then release
    set_id(1, 2'b01, 3'b001, 4'b0110, 5'd2, 5'd3, 5'd4);
    step("pre_hold");
    bus.ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 2'($urandom), 3'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step("hold");
    end
    bus.ex_hold = 0;
    set_id(1, 2'b10, 3'b100, 4'b1010, 5'd11, 5'd12, 5'd13);
    step("release");

    // Hold together with a hazard
    set_id(1, 2'b11, 3'b010, 4'b0001, 5'd9, 5'd6, 5'd0);
    step("lw6");
    set_id(1, 2'b10, 3'b000, 4'b1100, 5'd6, 5'd1, 5'd8);
    bus.ex_hold = 1;
    step("hold_hz");
    bus.ex_hold = 0;
    step("hold_hz_bubble");
    step("hold_hz_load");

    // Random traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 4) != 0, 2'($urandom), 3'($urandom), 4'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
      bus.flush   = ($urandom_range(0, 9) == 0);
      bus.ex_hold = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    bus.flush = 0; bus.ex_hold = 0;

    // Mid-run asynchronous reset with a valid instruction pending
    set_id(1, 2'b11, 3'b111, 4'b1111, 5'd1, 5'd2, 5'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset1.stall", {31'd0, bus.stall}, 32'd0);
    chk_outputs("reset1");
    @(posedge clk); #1 rst_n = 1'b1;
    step("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register for the five-stage MIPS core. It captures the decoded control bundle, the register-file read data, the 32-bit sign-extended immediate from the ID-stage extender, and the register addresses, then presents them to EX one cycle later. It also contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble into EX. Flush (taken branch) and downstream hold are handled here.

## Interface
- No parameters; all widths fixed by the MIPS32 datapath.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_wb_ctl  in  2  {RegWrite, MemtoReg}
- id_m_ctl  in  3  {Branch, MemRead, MemWrite}
- id_ex_ctl  in  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_npc  in  32  PC+4 of the ID instruction
- id_rd_data1 / id_rd_data2  in  32  register-file read data (rs, rt)
- id_sign_ext  in  32  sign-extended immediate
- id_rs / id_rt / id_rd  in  5  register addresses
- flush  in  1  taken branch; squash the ID instruction
- ex_hold  in  1  downstream memory wait; freeze this register
- ex_valid, ex_wb_ctl, ex_m_ctl, ex_ex_ctl, ex_npc, ex_rd_data1, ex_rd_data2, ex_sign_ext, ex_rs, ex_rt, ex_rd  out  (same widths)  registered copies
- stall  out  1  hold PC and IF/ID this cycle
- stall_count  out  32  number of load-use bubbles inserted

## Operation
- Hazard, combinational: `hz = id_valid & ex_valid & ex_m_ctl[1] & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- `stall = !flush & (ex_hold | hz)`.
- Per clock edge, in priority order:
  - **FLUSH** (`flush=1`): load a bubble.
  - **HOLD** (`ex_hold=1`): all registers keep their values.
  - **BUBBLE** (`hz=1`): load a bubble and increment `stall_count`.
  - **LOAD**: capture every `id_*` input into the matching `ex_*` register.
- Bubble contents:
  - `ex_valid`, `ex_wb_ctl`, `ex_m_ctl` and `ex_ex_ctl` become 0.
  - The data and address fields capture the `id_*` inputs normally; EX treats them as don't-care.
- LOAD with `id_valid=0`: `ex_valid=0`, and the control fields are cleared exactly as for a bubble.
- Both rs and rt are compared on every instruction (conservative). A false stall on an I-type rt is accepted.
- A load whose destination is $0 never stalls.
- The hazard lasts one cycle by construction. After the bubble, `ex_m_ctl[1]=0`, so `hz` drops and the stalled instruction loads.
- `stall_count` saturates at 0xFFFF_FFFF. It counts only BUBBLE cycles, never FLUSH or HOLD cycles.

## Timing
- Latency: exactly 1 cycle from the `id_*` inputs to the `ex_*` outputs.
- Reset: all `ex_*` outputs and `stall_count` become 0 asynchronously, so `stall` evaluates to 0.
  - Reset mid-stall discards the pending instruction; upstream refetches after reset.
- `stall` is combinational from `flush`, `ex_hold`, the `ex_*` registers and `id_rs`/`id_rt`/`id_valid`. No path exists from `stall` back into its own inputs.
- `flush` together with `hz`: the flush wins, `stall=0`, the bubble is not counted, and the squashed instruction is dropped.
- `ex_hold` together with `hz`: the register freezes and `stall=1`. The hazard re-evaluates once the hold releases.

## Configuration
- Macro: `ID_EX_STALL_COUNTER_EN`.
- Defined: the 32-bit saturating `stall_count` register is built as described above.
- Undefined: no counter register exists and `stall_count` is tied to 32'h0. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n=0` mid-run with valid inputs.
  - Required: all `ex_*` outputs, `stall` and `stall_count` are 0 immediately, without waiting for a clock edge.
- **Pass-through:** apply `id_sign_ext=32'hFFFFE13F`, `id_rs=3`, `id_rt=4`, `id_valid=1`, controls 0x2/0x0/0x3, and clock once.
  - Required: `ex_sign_ext=32'hFFFFE13F`, `ex_rs=3`, `ex_valid=1`, and the controls match the inputs.
- **Load-use:** EX holds `lw $5` (`ex_m_ctl=3'b010`, `ex_rt=5`, valid); ID holds `id_rs=5`.
  - Required: `stall=1` for exactly one cycle, and the next `ex_valid=0` with all control fields 0.
  - Then the ID instruction loads.
  - `stall_count` goes 0 -> 1.
- **No false hazard:** repeat the load-use case with `ex_rt=0`, `id_rs=0`.
  - Required: `stall=0`, and the ID instruction loads immediately.
- **Flush priority:** apply the load-use hazard and `flush=1` together.
  - Required: `stall=0`, the next `ex_valid=0`, and `stall_count` is unchanged.
- **Hold:** hold `ex_hold=1` for 3 cycles while the `id_*` inputs change.
  - Required: the `ex_*` outputs are frozen and `stall=1` throughout.
  - On release, the current ID inputs load on the next edge.
